// File: rtl/mem_io_responder.sv
// mem_io_responder: memory-side end of the CPU byte bus.
// Holds the RAM, decodes the I/O window at mem_a[17:16]==2'b11, buffers UART
// transmit/receive bytes in small FIFOs, and supplies the cycle counter and the
// sticky program-stop flag. rdy_in freezes only the CPU side; the UART side of
// both FIFOs keeps running.
module mem_io_responder #(
    parameter int ADDR_BITS = 17,
    parameter int TX_DEPTH  = 8,
    parameter int RX_DEPTH  = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [31:0] mem_a,
    input  logic [7:0]  mem_dout,
    input  logic        mem_wr,
    output logic [7:0]  mem_din,
    output logic        io_buffer_full,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        program_stop,
    output logic        tx_overflow
);

    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam logic [TX_AW:0] TX_FULL_LVL = (TX_AW + 1)'(TX_DEPTH);
    // two-entry margin absorbs the CPU's one-cycle reaction to the stall
    localparam logic [TX_AW:0] TX_NEAR_LVL = (TX_AW + 1)'(TX_DEPTH - 2);
    localparam logic [RX_AW:0] RX_FULL_LVL = (RX_AW + 1)'(RX_DEPTH);

    // address decode and qualified CPU strobes
    logic                 is_io;
    logic [2:0]           io_sel;
    logic                 cpu_wr;
    logic                 cpu_rd;
    logic [ADDR_BITS-1:0] ram_idx;
    logic                 unused_addr_bits;

    assign is_io   = (mem_a[17:16] == 2'b11);
    assign io_sel  = mem_a[2:0];
    assign cpu_wr  = rdy_in & mem_wr;
    assign cpu_rd  = rdy_in & ~mem_wr;
    assign ram_idx = mem_a[ADDR_BITS-1:0];
    assign unused_addr_bits = ^mem_a[31:18];

    // RAM (not reset) with a registered read port
    logic [7:0] ram [2**ADDR_BITS];
    logic [7:0] ram_q;

    // RAM write and synchronous read, only when the CPU side is running
    always_ff @(posedge clk_in) begin
        if (cpu_wr && !is_io) begin
            ram[ram_idx] <= mem_dout;
        end
        if (cpu_rd && !is_io) begin
            ram_q <= ram[ram_idx];
        end
    end

    // transmit FIFO
    logic [7:0]       tx_mem [TX_DEPTH];
    logic [TX_AW-1:0] tx_wr_ptr, tx_rd_ptr;
    logic [TX_AW:0]   tx_count;
    logic             tx_push_req, tx_push, tx_pop, tx_full;
    logic [7:0]       tx_push_data;

    // a 0x00 written to the data port is filtered; the stop port always pushes 0x00
    assign tx_push_req  = cpu_wr & is_io &
                          (((io_sel == 3'd0) & (mem_dout != 8'h00)) | (io_sel == 3'd4));
    assign tx_push_data = (io_sel == 3'd4) ? 8'h00 : mem_dout;
    assign tx_full      = (tx_count == TX_FULL_LVL);
    assign tx_valid     = (tx_count != '0);
    assign tx_pop       = tx_valid & tx_ready;
    // when full, a simultaneous pop frees the slot the push needs
    assign tx_push      = tx_push_req & (~tx_full | tx_pop);
    assign tx_data      = tx_valid ? tx_mem[tx_rd_ptr] : 8'h00;
    assign io_buffer_full = (tx_count >= TX_NEAR_LVL);

    // transmit FIFO storage
    always_ff @(posedge clk_in) begin
        if (tx_push) begin
            tx_mem[tx_wr_ptr] <= tx_push_data;
        end
    end

    // transmit FIFO pointers, count, overflow and program-stop flags
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            tx_wr_ptr    <= '0;
            tx_rd_ptr    <= '0;
            tx_count     <= '0;
            tx_overflow  <= 1'b0;
            program_stop <= 1'b0;
        end else begin
            if (tx_push) begin
                tx_wr_ptr <= tx_wr_ptr + TX_AW'(1);
            end
            if (tx_pop) begin
                tx_rd_ptr <= tx_rd_ptr + TX_AW'(1);
            end
            case ({tx_push, tx_pop})
                2'b10:   tx_count <= tx_count + (TX_AW + 1)'(1);
                2'b01:   tx_count <= tx_count - (TX_AW + 1)'(1);
                default: tx_count <= tx_count;
            endcase
            if (tx_push_req && !tx_push) begin
                tx_overflow <= 1'b1;
            end
            if (cpu_wr && is_io && (io_sel == 3'd4)) begin
                program_stop <= 1'b1;
            end
        end
    end

    // receive FIFO
    logic [7:0]       rx_mem [RX_DEPTH];
    logic [RX_AW-1:0] rx_wr_ptr, rx_rd_ptr;
    logic [RX_AW:0]   rx_count;
    logic             rx_push, rx_pop, rx_empty;

    assign rx_ready = (rx_count != RX_FULL_LVL);
    assign rx_empty = (rx_count == '0);
    assign rx_push  = rx_valid & rx_ready;
    // emptiness is judged before this cycle's push, so a coinciding push stays queued
    assign rx_pop   = cpu_rd & is_io & (io_sel == 3'd0) & ~rx_empty;

    // receive FIFO storage
    always_ff @(posedge clk_in) begin
        if (rx_push) begin
            rx_mem[rx_wr_ptr] <= rx_data;
        end
    end

    // receive FIFO pointers and count
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_count  <= '0;
        end else begin
            if (rx_push) begin
                rx_wr_ptr <= rx_wr_ptr + RX_AW'(1);
            end
            if (rx_pop) begin
                rx_rd_ptr <= rx_rd_ptr + RX_AW'(1);
            end
            case ({rx_push, rx_pop})
                2'b10:   rx_count <= rx_count + (RX_AW + 1)'(1);
                2'b01:   rx_count <= rx_count - (RX_AW + 1)'(1);
                default: rx_count <= rx_count;
            endcase
        end
    end

    // cycle counter, snapshot and I/O read data; sel_ram picks which read register drives mem_din
    logic [31:0] cnt;
    logic [31:0] snap;
    logic [7:0]  io_q;
    logic        sel_ram;

    // counter advances and reads are captured only while rdy_in is high
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            cnt     <= '0;
            snap    <= '0;
            io_q    <= 8'h00;
            sel_ram <= 1'b0;
        end else if (rdy_in) begin
            cnt <= cnt + 32'd1;
            if (!mem_wr) begin
                sel_ram <= ~is_io;
                if (is_io) begin
                    case (io_sel)
                        3'd0:    io_q <= rx_empty ? 8'h00 : rx_mem[rx_rd_ptr];
                        3'd4: begin
                            snap <= cnt;
                            io_q <= cnt[7:0];
                        end
                        3'd5:    io_q <= snap[15:8];
                        3'd6:    io_q <= snap[23:16];
                        3'd7:    io_q <= snap[31:24];
                        default: io_q <= 8'h00;
                    endcase
                end
            end
        end
    end

    assign mem_din = sel_ram ? ram_q : io_q;

endmodule
